l2_arbiter: RTL
===============

Name: l2_arbiter

Overview:
- Shares the single unified L2 cache (line-granular, 128-bit lines, 16-bit byte addresses) between the L1 instruction cache and the L1 data cache.
- Sits between the two L1 miss ports and the L2 CPU-side port.
- Accepts one outstanding line request at a time and latches its address and data.
- Arbitrates round-robin, sequences the L2 handshake, and returns a registered response to the winner.

Parameters:
- LINE_WIDTH, 128, cache line width in bits (matches cache_line)
- ADDR_WIDTH, 16, address width (matches lc3b_word)
- CNT_WIDTH, 16, width of each grant counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request; held high until i_resp
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache line write (writeback) request; held until d_resp
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  writeback line
- d_rdata  out  LINE_WIDTH  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- l2_read  out  1  read strobe to L2; held until l2_resp
- l2_write  out  1  write strobe to L2; held until l2_resp
- l2_address  out  ADDR_WIDTH  latched request address
- l2_wdata  out  LINE_WIDTH  latched write line
- l2_rdata  in  LINE_WIDTH  L2 read data, valid with l2_resp
- l2_resp  in  1  L2 completion pulse
- i_grant_count  out  CNT_WIDTH  number of I requests completed (wraps)
- d_grant_count  out  CNT_WIDTH  number of D requests completed (wraps)

Behaviour:
- Reset values:
  - State IDLE; last_grant = D, so I wins the first tie.
  - All strobes and resps 0.
  - l2_address, l2_wdata, i_rdata, d_rdata all 0.
  - Both counters 0.
- States:
  - IDLE: no request captured.
  - BUSY_I / BUSY_D: L2 transaction in flight for the named requester.
  - DONE_I / DONE_D: response cycle.
- IDLE transitions:
  - Only i_read pending: capture i_address, go to BUSY_I.
  - Only d_read or d_write pending: capture d_address and d_wdata, plus d_write as the op; go to BUSY_D.
  - Both pending: grant the requester not equal to last_grant, then update last_grant.
- Capture rule: captured values drive L2 from the next cycle. Request at cycle 0 gives l2_read/l2_write high at cycle 1.
- BUSY states:
  - l2_read = ~op_write and l2_write = op_write, held constant.
  - l2_address and l2_wdata are stable from the latches; later requester input changes are ignored.
  - On l2_resp: latch l2_rdata into the winner's rdata register (reads only; writes leave it unchanged), drop the strobe at the next edge, go to DONE_x.
- DONE states:
  - Winner's resp = 1 for exactly this one cycle; rdata valid.
  - Increment that requester's counter; CNT_WIDTH wrap-around is permitted.
  - Next state is unconditionally IDLE. The requester deasserts on seeing resp, so the completed request is never re-granted.
- Minimum latency: request in cycle 0, l2_resp in cycle k ≥ 1, resp in cycle k+1; next arbitration in cycle k+2.
- d_read and d_write both high: treated as a write.
- l2_resp while IDLE or DONE: ignored.
- Request arriving during BUSY/DONE: waits, never dropped. The losing requester is served directly after the current DONE (fairness bound: one transaction).
- rdata registers hold their value until the next completed read for that requester.
- Reset mid-transaction: at the reset edge, go to IDLE with all strobes and resps 0; the in-flight L2 transaction is abandoned.

Test Plan:
1. Lone I read of 0x1230, L2 responds 3 cycles after l2_read with line 0xAAAA…:
   - l2_read high with l2_address = 0x1230 in cycle 1; l2_resp in cycle 4.
   - i_resp=1 and i_rdata=0xAAAA… in cycle 5; i_grant_count=1.
2. i_read (0x0040) and d_write (0x0080, wdata 0x5555…) rise in the same cycle after reset:
   - I served first.
   - After its i_resp, IDLE, then l2_write=1 with address 0x0080 and wdata 0x5555….
   - d_resp pulses once; d_rdata unchanged at 0.
3. Both requesters continuously re-request for 6 transactions:
   - Grants alternate I, D, I, D, I, D.
   - Both counters read 3.
4. During BUSY_D, change d_address to 0xFFF0:
   - l2_address stays at the captured value until DONE.
5. Assert reset while BUSY_I with l2_read high:
   - Next cycle l2_read=0, i_resp=0, state IDLE, counters 0.
   - l2_resp pulsed afterwards produces no resp.
6. Preload i_grant_count to 0xFFFF via 65535 quick transactions (L2 model responding in 1 cycle), then one more:
   - Counter wraps to 0x0000; each transaction takes 4 cycles from request to next arbitration.

Source files
------------

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: L1 I/D miss ports, the shared L2 CPU-side port and the grant counters.
interface l2_arbiter_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;
  logic [CNT_WIDTH-1:0]  i_grant_count;
  logic [CNT_WIDTH-1:0]  d_grant_count;

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata,
           i_grant_count, d_grant_count
  );

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata,
           i_grant_count, d_grant_count
  );
endinterface

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin sharing of one L2 port between the L1 I and D caches,
// one latched request in flight, registered response back to the winner.
module l2_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input logic         clk,
  input logic         reset,
  l2_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_last_d;
  logic                  r_op_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;
  logic [CNT_WIDTH-1:0]  r_i_cnt;
  logic [CNT_WIDTH-1:0]  r_d_cnt;
  logic                  w_d_req;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_busy;

  assign w_d_req   = bus.d_read | bus.d_write;
  // on a tie the requester that did not win the previous grant goes first
  assign w_grant_i = bus.i_read & (~w_d_req | r_last_d);
  assign w_grant_d = w_d_req & (~bus.i_read | ~r_last_d);
  assign w_busy    = (r_state == BUSY_I) | (r_state == BUSY_D);

  always_comb begin
    w_next            = r_state;
    bus.l2_read       = 1'b0;
    bus.l2_write      = 1'b0;
    bus.i_resp        = 1'b0;
    bus.d_resp        = 1'b0;
    bus.l2_address    = r_addr;
    bus.l2_wdata      = r_wdata;
    bus.i_rdata       = r_i_rdata;
    bus.d_rdata       = r_d_rdata;
    bus.i_grant_count = r_i_cnt;
    bus.d_grant_count = r_d_cnt;
    case (r_state)
      IDLE:    w_next = w_grant_i ? BUSY_I : w_grant_d ? BUSY_D : IDLE;
      BUSY_I:  w_next = bus.l2_resp ? DONE_I : BUSY_I;
      BUSY_D:  w_next = bus.l2_resp ? DONE_D : BUSY_D;
      default: w_next = IDLE;
    endcase
    bus.l2_read  = w_busy & ~r_op_write;
    bus.l2_write = w_busy & r_op_write;
    bus.i_resp   = r_state == DONE_I;
    bus.d_resp   = r_state == DONE_D;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b1;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_cnt    <= '0;
      r_d_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_grant_i) begin
        r_last_d   <= 1'b0;
        r_op_write <= 1'b0;
        r_addr     <= bus.i_address;
      end else if (r_state == IDLE && w_grant_d) begin
        r_last_d   <= 1'b1;
        r_op_write <= bus.d_write;
        r_addr     <= bus.d_address;
        r_wdata    <= bus.d_wdata;
      end
      // counters step with the transition into DONE so they are current alongside resp
      if (r_state == BUSY_I && bus.l2_resp) begin
        r_i_rdata <= bus.l2_rdata;
        r_i_cnt   <= r_i_cnt + CNT_WIDTH'(1);
      end
      if (r_state == BUSY_D && bus.l2_resp) begin
        r_d_rdata <= r_op_write ? r_d_rdata : bus.l2_rdata;
        r_d_cnt   <= r_d_cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule
